sub_serial: RTL

Bit-serial unsigned subtractor, companion to the serial adder in the arithmetic datapath. On a start request it captures two WIDTH-bit operands and computes `a - b` one bit per clock, LSB first, using a single registered borrow. It presents the difference, a borrow-out (set when a < b unsigned) and a done flag. Area-constrained blocks use it in place of a parallel subtractor.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_sub.sv | 22 ++
 rtl/sub_serial.sv | 88 ++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared definitions for the serial arithmetic units
// Purpose: the state encoding and default width used by the serial adder and
// subtractor.
// Contents: state_t (IDLE/SUB/DONE), DEFAULT_WIDTH.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Encoding 2'd3 is unused; the FSMs treat it as a return-to-IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - 1-bit combinational full subtractor
// Purpose: computes one difference bit and the borrow into the next bit.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, a ^ b ^ bin
//   bout : borrow out
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when the subtrahend bit beats the minuend bit, or when they are
  // equal and an incoming borrow ripples through.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial unsigned subtractor, LSB first
// Purpose: captures a and b on a start request and computes a - b one bit per
// clock through a single full_sub cell and a registered borrow.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   en         : start request in IDLE, acknowledge/return in DONE
//   a, b       : operands, sampled only on the start edge
//   out        : difference (a - b) mod 2^WIDTH, valid while done is high
//   borrow_out : final borrow, 1 iff a < b
//   done       : high while the result is held
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             d;
  logic             borrow_next;

  full_sub u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow),
    .d    (d),
    .bout (borrow_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      count  <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            out    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            state  <= SUB;
          end
        end
        SUB: begin
          // Result bits enter at the MSB and shift down, so after WIDTH
          // steps bit 0 of the difference sits at out[0].
          out    <= {d, out[WIDTH-1:1]};
          borrow <= borrow_next;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          // Returning to IDLE is not a start; en must be seen again in IDLE.
          if (en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign borrow_out = borrow;
  assign done       = (state == DONE);

endmodule
